// File: rtl/mc_control_pkg.sv
// mc_control_pkg: opcode/funct constants, control-word encodings,
// sequencer state encodings and the decoded control word bundle.
package mc_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_MUL  = 6'h18;
  localparam logic [5:0] FUNCT_MULU = 6'h19;
  localparam logic [5:0] FUNCT_DIV  = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU = 6'h1b;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2a;
  localparam logic [5:0] FUNCT_SLTU = 6'h2b;

  localparam logic [5:0] ALU_OP_NOP  = 6'd0;
  localparam logic [5:0] ALU_OP_ADDU = 6'd1;
  localparam logic [5:0] ALU_OP_SUBU = 6'd2;
  localparam logic [5:0] ALU_OP_AND  = 6'd3;
  localparam logic [5:0] ALU_OP_OR   = 6'd4;
  localparam logic [5:0] ALU_OP_XOR  = 6'd5;
  localparam logic [5:0] ALU_OP_NOR  = 6'd6;
  localparam logic [5:0] ALU_OP_SLT  = 6'd7;
  localparam logic [5:0] ALU_OP_SLTU = 6'd8;
  localparam logic [5:0] ALU_OP_SLL  = 6'd9;
  localparam logic [5:0] ALU_OP_SRL  = 6'd10;
  localparam logic [5:0] ALU_OP_SRA  = 6'd11;
  localparam logic [5:0] ALU_OP_LUI  = 6'd12;
  localparam logic [5:0] ALU_OP_MUL  = 6'd13;
  localparam logic [5:0] ALU_OP_MUH  = 6'd14;
  localparam logic [5:0] ALU_OP_MULU = 6'd15;
  localparam logic [5:0] ALU_OP_MUHU = 6'd16;
  localparam logic [5:0] ALU_OP_DIV  = 6'd17;
  localparam logic [5:0] ALU_OP_MOD  = 6'd18;
  localparam logic [5:0] ALU_OP_DIVU = 6'd19;
  localparam logic [5:0] ALU_OP_MODU = 6'd20;
  localparam logic [5:0] ALU_OP_ADD  = 6'd21;
  localparam logic [5:0] ALU_OP_SUB  = 6'd22;
  localparam logic [5:0] ALU_OP_SLLV = 6'd23;
  localparam logic [5:0] ALU_OP_SRLV = 6'd24;
  localparam logic [5:0] ALU_OP_SRAV = 6'd25;

  localparam logic [3:0] PC_OP_NEXT = 4'd0;
  localparam logic [3:0] PC_OP_J    = 4'd1;
  localparam logic [3:0] PC_OP_JR   = 4'd2;
  localparam logic [3:0] PC_OP_BZ   = 4'd3;
  localparam logic [3:0] PC_OP_BNZ  = 4'd4;
  localparam logic [3:0] PC_OP_BLEZ = 4'd5;
  localparam logic [3:0] PC_OP_BGTZ = 4'd6;
  localparam logic [3:0] PC_OP_BLTZ = 4'd7;
  localparam logic [3:0] PC_OP_BGEZ = 4'd8;

  localparam logic [2:0] DM_OP_NONE = 3'd0;
  localparam logic [2:0] DM_OP_B    = 3'd1;
  localparam logic [2:0] DM_OP_BU   = 3'd2;
  localparam logic [2:0] DM_OP_H    = 3'd3;
  localparam logic [2:0] DM_OP_HU   = 3'd4;
  localparam logic [2:0] DM_OP_WD   = 3'd5;

  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_MEM = 2'd1;
  localparam logic [1:0] REG_SRC_PC  = 2'd2;
  localparam logic [1:0] REG_SRC_MDU = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_31 = 2'd2;

  localparam logic [1:0] EXT_OP_ZERO = 2'd0;
  localparam logic [1:0] EXT_OP_SIGN = 2'd1;
  localparam logic [1:0] EXT_OP_LUI  = 2'd2;

  typedef enum logic [2:0] {
    MC_ST_IDLE     = 3'd0,
    MC_ST_FETCH    = 3'd1,
    MC_ST_DECODE   = 3'd2,
    MC_ST_EXEC     = 3'd3,
    MC_ST_MDU_WAIT = 3'd4,
    MC_ST_MEM      = 3'd5,
    MC_ST_WB       = 3'd6,
    MC_ST_ERR      = 3'd7
  } mc_state_e;

  typedef struct packed {
    logic [5:0] alu_op;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] dm_op;
    logic [1:0] reg_src;
    logic [1:0] reg_dst;
    logic [3:0] pc_op;
  } ctrl_word_t;

  typedef struct packed {
    logic jump;
    logic link;
    logic branch;
    logic load;
    logic store;
    logic mdu;
    logic illegal;
  } ctrl_flags_t;

  localparam ctrl_word_t CW_NOP = '{
    alu_op:  ALU_OP_NOP,
    alu_src: 1'b0,
    ext_op:  EXT_OP_ZERO,
    dm_op:   DM_OP_NONE,
    reg_src: REG_SRC_ALU,
    reg_dst: REG_DST_RT,
    pc_op:   PC_OP_NEXT
  };

  // funct[1:0] picks MUL/MULU/DIV/DIVU, hi picks MUH/MUHU/MOD/MODU
  function automatic logic [5:0] mdu_alu_op(
    input logic [1:0] f,
    input logic       hi
  );
    return ALU_OP_MUL + {3'b000, f, 1'b0} + {5'b00000, hi};
  endfunction

endpackage

// File: rtl/mc_control_ctrl_decode.sv
// mc_control_ctrl_decode: combinational instr -> control word + class flags.
// Ports: instr (IR), cw (control word), fl (jump/link/branch/ld/st/mdu/ill).
module mc_control_ctrl_decode
  import mc_control_pkg::*;
#(
  parameter bit MDU_EN = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_word_t  cw,
  output ctrl_flags_t fl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       sop_hint;
  logic       unused_bits;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  // MDU ops carry sop code 2 (low) or 3 (high) in the shamt field
  assign sop_hint    = (instr[10:7] == 4'b0001);
  assign unused_bits = ^{instr[25:21], instr[15:11]};

  always_comb begin
    cw = CW_NOP;
    fl = '0;
    unique case (1'b1)
      op == OP_SPECIAL: begin
        cw.reg_dst = REG_DST_RD;
        unique case (funct)
          FUNCT_SLL:  cw.alu_op = ALU_OP_SLL;
          FUNCT_SRL:  cw.alu_op = ALU_OP_SRL;
          FUNCT_SRA:  cw.alu_op = ALU_OP_SRA;
          FUNCT_SLLV: cw.alu_op = ALU_OP_SLLV;
          FUNCT_SRLV: cw.alu_op = ALU_OP_SRLV;
          FUNCT_SRAV: cw.alu_op = ALU_OP_SRAV;
          FUNCT_ADD:  cw.alu_op = ALU_OP_ADD;
          FUNCT_ADDU: cw.alu_op = ALU_OP_ADDU;
          FUNCT_SUB:  cw.alu_op = ALU_OP_SUB;
          FUNCT_SUBU: cw.alu_op = ALU_OP_SUBU;
          FUNCT_AND:  cw.alu_op = ALU_OP_AND;
          FUNCT_OR:   cw.alu_op = ALU_OP_OR;
          FUNCT_XOR:  cw.alu_op = ALU_OP_XOR;
          FUNCT_NOR:  cw.alu_op = ALU_OP_NOR;
          FUNCT_SLT:  cw.alu_op = ALU_OP_SLT;
          FUNCT_SLTU: cw.alu_op = ALU_OP_SLTU;
          FUNCT_JR: begin
            fl.jump  = 1'b1;
            cw.pc_op = PC_OP_JR;
          end
          FUNCT_JALR: begin
            fl.jump    = 1'b1;
            fl.link    = 1'b1;
            cw.pc_op   = PC_OP_JR;
            cw.reg_src = REG_SRC_PC;
          end
          FUNCT_MUL, FUNCT_MULU,
          FUNCT_DIV, FUNCT_DIVU: begin
            if (sop_hint) begin
              fl.mdu     = 1'b1;
              cw.alu_op  = mdu_alu_op(funct[1:0], instr[6]);
              cw.reg_src = REG_SRC_MDU;
            end else begin
              fl.illegal = 1'b1;
            end
          end
          default: fl.illegal = 1'b1;
        endcase
      end
      op == OP_REGIMM: begin
        cw.ext_op = EXT_OP_SIGN;
        fl.branch = 1'b1;
        unique case (rt)
          5'h00: cw.pc_op = PC_OP_BLTZ;
          5'h01: cw.pc_op = PC_OP_BGEZ;
          5'h10, 5'h11: begin
            cw.pc_op   = rt[0] ? PC_OP_BGEZ : PC_OP_BLTZ;
            cw.reg_src = REG_SRC_PC;
            cw.reg_dst = REG_DST_31;
            fl.link    = 1'b1;
          end
          default: fl.illegal = 1'b1;
        endcase
      end
      op == OP_J: begin
        fl.jump  = 1'b1;
        cw.pc_op = PC_OP_J;
      end
      op == OP_JAL: begin
        fl.jump    = 1'b1;
        fl.link    = 1'b1;
        cw.pc_op   = PC_OP_J;
        cw.reg_src = REG_SRC_PC;
        cw.reg_dst = REG_DST_31;
      end
      op == OP_BEQ, op == OP_BNE,
      op == OP_BLEZ, op == OP_BGTZ: begin
        fl.branch = 1'b1;
        cw.alu_op = ALU_OP_SUBU;
        cw.ext_op = EXT_OP_SIGN;
        unique case (op[1:0])
          2'd0:    cw.pc_op = PC_OP_BZ;
          2'd1:    cw.pc_op = PC_OP_BNZ;
          2'd2:    cw.pc_op = PC_OP_BLEZ;
          default: cw.pc_op = PC_OP_BGTZ;
        endcase
      end
      op == OP_ADDI, op == OP_ADDIU,
      op == OP_SLTI, op == OP_SLTIU,
      op == OP_ANDI, op == OP_ORI,
      op == OP_XORI, op == OP_LUI: begin
        cw.alu_src = 1'b1;
        cw.reg_dst = REG_DST_RT;
        cw.ext_op  = EXT_OP_SIGN;
        unique case (op[2:0])
          3'd0: cw.alu_op = ALU_OP_ADD;
          3'd1: cw.alu_op = ALU_OP_ADDU;
          3'd2: cw.alu_op = ALU_OP_SLT;
          3'd3: cw.alu_op = ALU_OP_SLTU;
          3'd4: begin
            cw.alu_op = ALU_OP_AND;
            cw.ext_op = EXT_OP_ZERO;
          end
          3'd5: begin
            cw.alu_op = ALU_OP_OR;
            cw.ext_op = EXT_OP_ZERO;
          end
          3'd6: begin
            cw.alu_op = ALU_OP_XOR;
            cw.ext_op = EXT_OP_ZERO;
          end
          default: begin
            cw.alu_op = ALU_OP_LUI;
            cw.ext_op = EXT_OP_LUI;
          end
        endcase
      end
      op == OP_LB, op == OP_LH, op == OP_LW,
      op == OP_LBU, op == OP_LHU: begin
        fl.load    = 1'b1;
        cw.alu_op  = ALU_OP_ADDU;
        cw.alu_src = 1'b1;
        cw.ext_op  = EXT_OP_SIGN;
        cw.reg_src = REG_SRC_MEM;
        cw.reg_dst = REG_DST_RT;
        unique case (op[2:0])
          3'd0:    cw.dm_op = DM_OP_B;
          3'd1:    cw.dm_op = DM_OP_H;
          3'd3:    cw.dm_op = DM_OP_WD;
          3'd4:    cw.dm_op = DM_OP_BU;
          default: cw.dm_op = DM_OP_HU;
        endcase
      end
      op == OP_SB, op == OP_SH, op == OP_SW: begin
        fl.store   = 1'b1;
        cw.alu_op  = ALU_OP_ADDU;
        cw.alu_src = 1'b1;
        cw.ext_op  = EXT_OP_SIGN;
        unique case (op[1:0])
          2'd0:    cw.dm_op = DM_OP_B;
          2'd1:    cw.dm_op = DM_OP_H;
          default: cw.dm_op = DM_OP_WD;
        endcase
      end
      default: fl.illegal = 1'b1;
    endcase
    if (fl.mdu && !MDU_EN) begin
      fl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Ports: instr, im/dm/mdu handshakes in; PC/IR/ALU/DM/RF controls out.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter bit MDU_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        im_ack,
  input  logic        dm_ack,
  input  logic        mdu_done,
  output logic        im_req,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [3:0]  pc_op,
  output logic [5:0]  alu_op,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic        dm_req,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic [2:0]  dm_op,
  output logic        mdu_start,
  output logic        reg_wr,
  output logic [1:0]  reg_src,
  output logic [1:0]  reg_dst,
  output logic        ill_instr,
  output logic        bus_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mc_state_e   state_q, state_d;
  ctrl_word_t  dec_cw, cw_d, cw_q, cw_o;
  ctrl_flags_t dec_fl;
  logic        br_q, lk_q, ld_q, st_q, md_q;
  logic [TW-1:0] tcnt_q;
  logic        tmo;

  mc_control_ctrl_decode #(
    .MDU_EN (MDU_EN)
  ) u_dec (
    .instr (instr),
    .cw    (dec_cw),
    .fl    (dec_fl)
  );

  // an illegal instruction retires as a NOP
  assign cw_d = dec_fl.illegal ? CW_NOP : dec_cw;

  // jumps act in DECODE, so the fields come straight
  // from the decoder there and from the latched word after
  assign cw_o = (state_q == MC_ST_DECODE) ? cw_d : cw_q;

  assign alu_op  = cw_o.alu_op;
  assign alu_src = cw_o.alu_src;
  assign ext_op  = cw_o.ext_op;
  assign dm_op   = cw_o.dm_op;
  assign reg_src = cw_o.reg_src;
  assign reg_dst = cw_o.reg_dst;
  assign pc_op   = (state_q == MC_ST_FETCH) ? PC_OP_NEXT
                                            : cw_o.pc_op;

  // last wait cycle before the bus is declared dead
  assign tmo = (TIMEOUT != 0) && (tcnt_q == TLIM);

  always_comb begin
    state_d   = state_q;
    im_req    = 1'b0;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    dm_req    = 1'b0;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    mdu_start = 1'b0;
    reg_wr    = 1'b0;
    ill_instr = 1'b0;
    bus_err   = 1'b0;
    unique case (state_q)
      MC_ST_IDLE: state_d = MC_ST_FETCH;
      MC_ST_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = MC_ST_DECODE;
        end else if (tmo) begin
          state_d = MC_ST_ERR;
        end
      end
      MC_ST_DECODE: begin
        if (dec_fl.illegal) begin
          ill_instr = 1'b1;
          state_d   = MC_ST_FETCH;
        end else if (dec_fl.jump) begin
          pc_wr   = 1'b1;
          reg_wr  = dec_fl.link;
          state_d = MC_ST_FETCH;
        end else begin
          state_d = MC_ST_EXEC;
        end
      end
      MC_ST_EXEC: begin
        unique case (1'b1)
          br_q: begin
            pc_wr   = 1'b1;
            reg_wr  = lk_q;
            state_d = MC_ST_FETCH;
          end
          md_q: begin
            mdu_start = 1'b1;
            state_d   = MC_ST_MDU_WAIT;
          end
          ld_q, st_q: state_d = MC_ST_MEM;
          default:    state_d = MC_ST_WB;
        endcase
      end
      MC_ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = MC_ST_WB;
        end
      end
      MC_ST_MEM: begin
        dm_req = 1'b1;
        dm_rd  = ld_q;
        dm_wr  = st_q;
        if (dm_ack) begin
          state_d = ld_q ? MC_ST_WB : MC_ST_FETCH;
        end else if (tmo) begin
          state_d = MC_ST_ERR;
        end
      end
      MC_ST_WB: begin
        reg_wr  = 1'b1;
        state_d = MC_ST_FETCH;
      end
      MC_ST_ERR: bus_err = 1'b1;
      default:   state_d = MC_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MC_ST_IDLE;
      cw_q    <= CW_NOP;
      br_q    <= 1'b0;
      lk_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      md_q    <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MC_ST_DECODE) begin
        cw_q <= cw_d;
        br_q <= dec_fl.branch & ~dec_fl.illegal;
        lk_q <= dec_fl.link & ~dec_fl.illegal;
        ld_q <= dec_fl.load & ~dec_fl.illegal;
        st_q <= dec_fl.store & ~dec_fl.illegal;
        md_q <= dec_fl.mdu & ~dec_fl.illegal;
      end
      // a state change always restarts the wait count,
      // which covers every entry into FETCH and MEM
      if (state_d != state_q) begin
        tcnt_q <= '0;
      end else if (state_q == MC_ST_FETCH ||
                   state_q == MC_ST_MEM) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed-step bench for mc_control.
// Two instances share stimulus: MDU enabled and MDU disabled.
module tb_mc_control;
  import mc_control_pkg::*;

  localparam logic [31:0] I_ADDIU = 32'h2401_0005;
  localparam logic [31:0] I_LW    = 32'h8c22_0004;
  localparam logic [31:0] I_SW    = 32'hac22_0004;
  localparam logic [31:0] I_MUL   = 32'h0043_2098;
  localparam logic [31:0] I_JAL   = 32'h0c00_0010;
  localparam logic [31:0] I_BEQ   = 32'h1022_0003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        im_ack, dm_ack, mdu_done;

  logic       im_req, ir_wr, pc_wr, alu_src;
  logic [3:0] pc_op;
  logic [5:0] alu_op;
  logic [1:0] ext_op, reg_src, reg_dst;
  logic       dm_req, dm_rd, dm_wr, mdu_start;
  logic [2:0] dm_op;
  logic       reg_wr, ill_instr, bus_err;

  logic       im_req_b, ir_wr_b, pc_wr_b, alu_src_b;
  logic [3:0] pc_op_b;
  logic [5:0] alu_op_b;
  logic [1:0] ext_op_b, reg_src_b, reg_dst_b;
  logic       dm_req_b, dm_rd_b, dm_wr_b, mdu_start_b;
  logic [2:0] dm_op_b;
  logic       reg_wr_b, ill_instr_b, bus_err_b;

  logic [29:0] outs;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0, n_req, n_st, n_st_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign outs = {im_req, ir_wr, pc_wr, pc_op, alu_op,
                 alu_src, ext_op, dm_req, dm_rd, dm_wr,
                 dm_op, mdu_start, reg_wr, reg_src,
                 reg_dst, ill_instr, bus_err};

  mc_control #(.TIMEOUT(16), .MDU_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .im_ack(im_ack), .dm_ack(dm_ack),
    .mdu_done(mdu_done),
    .im_req(im_req), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_op(pc_op), .alu_op(alu_op), .alu_src(alu_src),
    .ext_op(ext_op), .dm_req(dm_req), .dm_rd(dm_rd),
    .dm_wr(dm_wr), .dm_op(dm_op),
    .mdu_start(mdu_start), .reg_wr(reg_wr),
    .reg_src(reg_src), .reg_dst(reg_dst),
    .ill_instr(ill_instr), .bus_err(bus_err)
  );

  mc_control #(.TIMEOUT(16), .MDU_EN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .im_ack(im_ack), .dm_ack(dm_ack),
    .mdu_done(mdu_done),
    .im_req(im_req_b), .ir_wr(ir_wr_b),
    .pc_wr(pc_wr_b), .pc_op(pc_op_b),
    .alu_op(alu_op_b), .alu_src(alu_src_b),
    .ext_op(ext_op_b), .dm_req(dm_req_b),
    .dm_rd(dm_rd_b), .dm_wr(dm_wr_b),
    .dm_op(dm_op_b), .mdu_start(mdu_start_b),
    .reg_wr(reg_wr_b), .reg_src(reg_src_b),
    .reg_dst(reg_dst_b), .ill_instr(ill_instr_b),
    .bus_err(bus_err_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st();
    return 32'(u_dut.state_q);
  endfunction

  initial begin
    rst_n    = 1'b0;
    instr    = I_ADDIU;
    im_ack   = 1'b0;
    dm_ack   = 1'b0;
    mdu_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outs", 32'(outs), 32'h0);
    chk("rst_state", st(), 32'(MC_ST_IDLE));

    // ADDIU, zero-wait fetch
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(im_req), 32'h0);
    tick();
    im_ack = 1'b1;
    #1;
    chk("addiu_f_st", st(), 32'(MC_ST_FETCH));
    chk("addiu_f_io",
        32'({im_req, ir_wr, pc_wr, pc_op}), 32'h70);
    tick();
    im_ack = 1'b0;
    #1;
    chk("addiu_d_st", st(), 32'(MC_ST_DECODE));
    chk("addiu_d_rw", 32'(reg_wr), 32'h0);
    tick();
    chk("addiu_e_st", st(), 32'(MC_ST_EXEC));
    chk("addiu_e_rw", 32'(reg_wr), 32'h0);
    chk("addiu_aluop", 32'(alu_op), 32'(ALU_OP_ADDU));
    chk("addiu_alusrc", 32'(alu_src), 32'h1);
    tick();
    chk("addiu_wb_st", st(), 32'(MC_ST_WB));
    chk("addiu_wb_rw", 32'(reg_wr), 32'h1);
    tick();
    chk("addiu_end_st", st(), 32'(MC_ST_FETCH));
    chk("addiu_end_rw", 32'(reg_wr), 32'h0);

    // LW, data ack after 3 wait cycles
    c0 = cyc;
    instr  = I_LW;
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    tick();
    chk("lw_e_st", st(), 32'(MC_ST_EXEC));
    n_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dm_ack = 1'b1;
      #1;
      if (dm_req && dm_rd && !dm_wr) n_req++;
    end
    chk("lw_dmop", 32'(dm_op), 32'(DM_OP_WD));
    chk("lw_req_cyc", 32'(n_req), 32'd4);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("lw_wb_st", st(), 32'(MC_ST_WB));
    chk("lw_wb_rw", 32'({reg_wr, dm_req}), 32'h2);
    tick();
    chk("lw_end_st", st(), 32'(MC_ST_FETCH));
    chk("lw_cycles", 32'(cyc - c0), 32'd8);

    // JAL acts in DECODE
    instr  = I_JAL;
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    #1;
    chk("jal_d_st", st(), 32'(MC_ST_DECODE));
    chk("jal_d_wr", 32'({pc_wr, reg_wr}), 32'h3);
    chk("jal_dst", 32'(reg_dst), 32'(REG_DST_31));
    chk("jal_src", 32'(reg_src), 32'(REG_SRC_PC));
    chk("jal_pcop", 32'(pc_op), 32'(PC_OP_J));
    tick();
    chk("jal_end_st", st(), 32'(MC_ST_FETCH));

    // BEQ acts in EXEC
    instr  = I_BEQ;
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    #1;
    chk("beq_d_pcwr", 32'(pc_wr), 32'h0);
    tick();
    chk("beq_e_st", st(), 32'(MC_ST_EXEC));
    chk("beq_e_io", 32'({pc_wr, reg_wr}), 32'h2);
    chk("beq_pcop", 32'(pc_op), 32'(PC_OP_BZ));
    tick();
    chk("beq_end_st", st(), 32'(MC_ST_FETCH));
    chk("beq_f_pcop", 32'(pc_op), 32'(PC_OP_NEXT));

    // SW, zero-wait
    c0 = cyc;
    instr  = I_SW;
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    tick();
    tick();
    dm_ack = 1'b1;
    #1;
    chk("sw_m_io",
        32'({dm_req, dm_rd, dm_wr, dm_op}), 32'h2d);
    tick();
    dm_ack = 1'b0;
    #1;
    chk("sw_end_st", st(), 32'(MC_ST_FETCH));
    chk("sw_cycles", 32'(cyc - c0), 32'd4);

    // SW again, reset while waiting in MEM
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    tick();
    tick();
    chk("swr_m_req", 32'(dm_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("swr_rst_outs", 32'(outs), 32'h0);
    chk("swr_rst_st", st(), 32'(MC_ST_IDLE));
    rst_n = 1'b1;
    #1;
    chk("swr_idle", 32'({st(), im_req}), 32'h0);
    tick();
    chk("swr_req", 32'(im_req), 32'h1);

    // MUL with MDU enabled vs disabled
    instr  = I_MUL;
    im_ack = 1'b1;
    n_st   = 0;
    n_st_b = 0;
    tick();
    im_ack = 1'b0;
    #1;
    chk("mul_ill", 32'(ill_instr), 32'h0);
    chk("mul_ill_b", 32'(ill_instr_b), 32'h1);
    n_st   += int'(mdu_start);
    n_st_b += int'(mdu_start_b);
    tick();
    chk("mul_e_st", st(), 32'(MC_ST_EXEC));
    n_st   += int'(mdu_start);
    n_st_b += int'(mdu_start_b);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) mdu_done = 1'b1;
      #1;
      chk("mul_wait_st", st(), 32'(MC_ST_MDU_WAIT));
      n_st   += int'(mdu_start);
      n_st_b += int'(mdu_start_b);
    end
    tick();
    mdu_done = 1'b0;
    #1;
    chk("mul_wb_st", st(), 32'(MC_ST_WB));
    chk("mul_wb_rw", 32'(reg_wr), 32'h1);
    chk("mul_wb_src", 32'(reg_src), 32'(REG_SRC_MDU));
    chk("mul_starts", 32'(n_st), 32'd1);
    chk("mul_starts_b", 32'(n_st_b), 32'd0);
    tick();
    chk("mul_end_st", st(), 32'(MC_ST_FETCH));

    // ack on the last allowed fetch cycle wins
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    im_ack = 1'b1;
    #1;
    chk("tmo_edge_ir", 32'({im_req, ir_wr}), 32'h3);
    tick();
    im_ack = 1'b0;
    #1;
    chk("tmo_edge_st", st(), 32'(MC_ST_DECODE));
    chk("tmo_edge_err", 32'(bus_err), 32'h0);

    // no im_ack at all: ERR after 16 request cycles
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    n_req = 0;
    for (int i = 0; i < 16; i++) begin
      if (im_req) n_req++;
      tick();
    end
    chk("tmo_req_cyc", 32'(n_req), 32'd16);
    chk("tmo_st", st(), 32'(MC_ST_ERR));
    chk("tmo_io", 32'({bus_err, im_req}), 32'h2);
    im_ack = 1'b1;
    #1;
    chk("err_ack_ign", 32'({ir_wr, pc_wr, im_req}), 32'h0);
    repeat (3) tick();
    chk("err_sticky", 32'({bus_err, im_req}), 32'h2);
    im_ack = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("err_rst", 32'(outs), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("err_rst_req", 32'(im_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
